// File: rtl/syn_pipe_ctrl_pkg.sv
// rtl/syn_pipe_ctrl_pkg.sv - shared state encodings and redirect-select codes
package syn_pipe_ctrl_pkg;

    // Redirect mux codes of the ID/EX operand selects
    localparam logic [1:0] MUX_EX_REDIR_OLD = 2'b00;
    localparam logic [1:0] MUX_EX_REDIR_EX  = 2'b01;
    localparam logic [1:0] MUX_EX_REDIR_DM  = 2'b10;

    // Forwarding selects are the redirect mux codes under hazard-unit names
    localparam logic [1:0] FWD_OLD = MUX_EX_REDIR_OLD;
    localparam logic [1:0] FWD_EX  = MUX_EX_REDIR_EX;
    localparam logic [1:0] FWD_DM  = MUX_EX_REDIR_DM;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HALT  = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/syn_pipe_ctrl_hazard.sv
// rtl/syn_pipe_ctrl_hazard.sv - register comparators for forwarding and load-use detection
module syn_pipe_ctrl_hazard
    import syn_pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic [4:0] ex_req_w_i,
    input  logic       ex_w_en_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] dm_req_w_i,
    input  logic       dm_w_en_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       load_use_o
);

    logic ex_hit_rs;
    logic ex_hit_rt;
    logic dm_hit_rs;
    logic dm_hit_rt;

    // Match the producers in EX and DM against each used, non-zero source register
    always_comb begin
        ex_hit_rs = id_use_rs_i && ex_w_en_i && (ex_req_w_i == id_rs_i) && (id_rs_i != 5'd0);
        ex_hit_rt = id_use_rt_i && ex_w_en_i && (ex_req_w_i == id_rt_i) && (id_rt_i != 5'd0);
        dm_hit_rs = id_use_rs_i && dm_w_en_i && (dm_req_w_i == id_rs_i) && (id_rs_i != 5'd0);
        dm_hit_rt = id_use_rt_i && dm_w_en_i && (dm_req_w_i == id_rt_i) && (id_rt_i != 5'd0);
    end

    // The younger producer in EX wins over the older one in DM
    always_comb begin
        fwd_a_o = ex_hit_rs ? FWD_EX : (dm_hit_rs ? FWD_DM : FWD_OLD);
        fwd_b_o = ex_hit_rt ? FWD_EX : (dm_hit_rt ? FWD_DM : FWD_OLD);
    end

    // A load result is not available until DM, so a consumer right behind it must wait
    always_comb begin
        load_use_o = ex_is_load_i && ex_w_en_i && (ex_req_w_i != 5'd0) &&
                     ((id_use_rs_i && (ex_req_w_i == id_rs_i)) ||
                      (id_use_rt_i && (ex_req_w_i == id_rt_i)));
    end

endmodule

// File: rtl/syn_pipe_ctrl.sv
// rtl/syn_pipe_ctrl.sv - pipeline stall/flush/halt controller with performance counters
module syn_pipe_ctrl
    import syn_pipe_ctrl_pkg::*;
#(
    parameter int CNT_BIT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic [4:0]         ex_req_w,
    input  logic               ex_w_en,
    input  logic               ex_is_load,
    input  logic [4:0]         dm_req_w,
    input  logic               dm_w_en,
    input  logic               load_pc,
    input  logic               halt_ex,
    input  logic               halt_wb,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               if_id_clr,
    output logic               id_ex_clr,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               halted,
    output logic [CNT_BIT-1:0] stall_cnt,
    output logic [CNT_BIT-1:0] flush_cnt,
    output logic [CNT_BIT-1:0] cycle_cnt
);

    localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

    pipe_state_e        state_q;
    pipe_state_e        state_d;
    logic               load_use;
    logic               stall_inc;
    logic               flush_inc;
    logic [CNT_BIT-1:0] stall_cnt_q;
    logic [CNT_BIT-1:0] flush_cnt_q;
    logic [CNT_BIT-1:0] cycle_cnt_q;

    syn_pipe_ctrl_hazard u_hazard (
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rs_i  (id_use_rs),
        .id_use_rt_i  (id_use_rt),
        .ex_req_w_i   (ex_req_w),
        .ex_w_en_i    (ex_w_en),
        .ex_is_load_i (ex_is_load),
        .dm_req_w_i   (dm_req_w),
        .dm_w_en_i    (dm_w_en),
        .fwd_a_o      (fwd_a),
        .fwd_b_o      (fwd_b),
        .load_use_o   (load_use)
    );

    // Zero-latency pipeline controls and next state; halt beats branch flush beats load-use
    always_comb begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_clr = 1'b0;
        halted    = 1'b0;
        state_d   = state_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!rst_n) begin
            state_d = ST_RUN;
        end else if (!en) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            halted   = (state_q == ST_HALT);
        end else begin
            unique case (state_q)
                ST_RUN, ST_STALL: begin
                    if (halt_ex) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        if_id_clr = 1'b1;
                        id_ex_clr = 1'b1;
                        state_d   = ST_DRAIN;
                    end else if (load_pc) begin
                        if_id_clr = 1'b1;
                        id_ex_clr = 1'b1;
                        flush_inc = 1'b1;
                        state_d   = ST_RUN;
                    end else if (load_use) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_clr = 1'b1;
                        stall_inc = 1'b1;
                        state_d   = ST_STALL;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    if_id_clr = 1'b1;
                    id_ex_clr = 1'b1;
                    if (halt_wb) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    if_id_clr = 1'b1;
                    id_ex_clr = 1'b1;
                    halted    = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and counters advance only on enabled cycles; counters wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else if (en) begin
            state_q <= state_d;
            if (stall_inc) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_inc) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
            if (state_q != ST_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_syn_pipe_ctrl.sv
// tb/tb_syn_pipe_ctrl.sv - directed self-checking bench for syn_pipe_ctrl
module tb_syn_pipe_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [4:0]    ex_req_w;
    logic          ex_w_en;
    logic          ex_is_load;
    logic [4:0]    dm_req_w;
    logic          dm_w_en;
    logic          load_pc;
    logic          halt_ex;
    logic          halt_wb;
    logic          pc_en;
    logic          if_id_en;
    logic          if_id_clr;
    logic          id_ex_clr;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    syn_pipe_ctrl #(.CNT_BIT(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_req_w   (ex_req_w),
        .ex_w_en    (ex_w_en),
        .ex_is_load (ex_is_load),
        .dm_req_w   (dm_req_w),
        .dm_w_en    (dm_w_en),
        .load_pc    (load_pc),
        .halt_ex    (halt_ex),
        .halt_wb    (halt_wb),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .if_id_clr  (if_id_clr),
        .id_ex_clr  (id_ex_clr),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        en = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_req_w = 5'd0; ex_w_en = 1'b0; ex_is_load = 1'b0;
        dm_req_w = 5'd0; dm_w_en = 1'b0; load_pc = 1'b0; halt_ex = 1'b0; halt_wb = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_w_en = 1'b1; ex_req_w = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        load_pc = 1'b1; halt_ex = 1'b1;
        #2;
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_pc_en: got %b expected 1", pc_en); end
        checks++; if (if_id_en !== 1'b1) begin errors++; $display("FAIL rst_if_id_en: got %b expected 1", if_id_en); end
        checks++; if ({if_id_clr, id_ex_clr} !== 2'b00) begin errors++; $display("FAIL rst_clears: got %b expected 00", {if_id_clr, id_ex_clr}); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if ({stall_cnt, flush_cnt, cycle_cnt} !== '0) begin errors++; $display("FAIL rst_counters: got %h expected 0", {stall_cnt, flush_cnt, cycle_cnt}); end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++; if (cycle_cnt !== 4'd1) begin errors++; $display("FAIL rst_first_cycle: got %0d expected 1", cycle_cnt); end
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_first_run: got %b expected 1", pc_en); end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use();
        #1;
        checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr} !== 4'b0001) begin errors++; $display("FAIL lu_stall_ctrl: got %b expected 0001", {pc_en, if_id_en, if_id_clr, id_ex_clr}); end
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a_ex: got %b expected 01", fwd_a); end
        tick();
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
        ex_is_load = 1'b0; ex_w_en = 1'b0; ex_req_w = 5'd0;
        dm_w_en = 1'b1; dm_req_w = 5'd8;
        #1;
        checks++; if ({pc_en, if_id_en, id_ex_clr} !== 3'b110) begin errors++; $display("FAIL lu_stall_release: got %b expected 110", {pc_en, if_id_en, id_ex_clr}); end
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a_dm: got %b expected 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b_old: got %b expected 00", fwd_b); end
        tick();
        checks++; if (stall_cnt !== 4'd1 || cycle_cnt !== 4'd2) begin errors++; $display("FAIL lu_after: got stall %0d cycle %0d expected 1 2", stall_cnt, cycle_cnt); end
    endtask

    task automatic test_forward();
        apply_reset();
        ex_w_en = 1'b1; ex_req_w = 5'd9; dm_w_en = 1'b1; dm_req_w = 5'd9;
        id_rs = 5'd9; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_ex_prio: got %b expected 0101", {fwd_a, fwd_b}); end
        checks++; if (pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b%b expected 10", pc_en, id_ex_clr); end
        id_rs = 5'd0; id_rt = 5'd0;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_r0: got %b expected 0000", {fwd_a, fwd_b}); end
        ex_req_w = 5'd3; id_rs = 5'd9; id_rt = 5'd3;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin errors++; $display("FAIL fwd_dm_ex_mix: got %b expected 1001", {fwd_a, fwd_b}); end
        id_use_rt = 1'b0;
        #1;
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_unused_rt: got %b expected 00", fwd_b); end
    endtask

    task automatic test_flush();
        apply_reset();
        set_load_use();
        load_pc = 1'b1;
        #1;
        checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr} !== 4'b1111) begin errors++; $display("FAIL fl_ctrl: got %b expected 1111", {pc_en, if_id_en, if_id_clr, id_ex_clr}); end
        tick();
        checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL fl_counts: got flush %0d stall %0d expected 1 0", flush_cnt, stall_cnt); end
        load_pc = 1'b0;
        #1;
        checks++; if ({pc_en, id_ex_clr} !== 2'b01) begin errors++; $display("FAIL fl_then_stall: got %b expected 01", {pc_en, id_ex_clr}); end
        tick();
        checks++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin errors++; $display("FAIL fl_then_counts: got stall %0d flush %0d expected 1 1", stall_cnt, flush_cnt); end
    endtask

    task automatic test_halt();
        apply_reset();
        tick();
        halt_ex = 1'b1; load_pc = 1'b1; set_load_use();
        #1;
        checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr, halted} !== 5'b00110) begin errors++; $display("FAIL ht_entry: got %b expected 00110", {pc_en, if_id_en, if_id_clr, id_ex_clr, halted}); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({pc_en, id_ex_clr, halted} !== 3'b010) begin errors++; $display("FAIL ht_drain1: got %b expected 010", {pc_en, id_ex_clr, halted}); end
        checks++; if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0 || cycle_cnt !== 4'd2) begin errors++; $display("FAIL ht_drain1_cnt: got %0d %0d %0d expected 0 0 2", flush_cnt, stall_cnt, cycle_cnt); end
        tick();
        halt_wb = 1'b1;
        #1;
        checks++; if ({pc_en, id_ex_clr, halted} !== 3'b010) begin errors++; $display("FAIL ht_drain2: got %b expected 010", {pc_en, id_ex_clr, halted}); end
        tick();
        halt_wb = 1'b0;
        load_pc = 1'b1;
        #1;
        checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr, halted} !== 5'b00111) begin errors++; $display("FAIL ht_halted: got %b expected 00111", {pc_en, if_id_en, if_id_clr, id_ex_clr, halted}); end
        checks++; if (cycle_cnt !== 4'd4) begin errors++; $display("FAIL ht_cycle_at_halt: got %0d expected 4", cycle_cnt); end
        repeat (3) tick();
        checks++; if (halted !== 1'b1 || cycle_cnt !== 4'd4 || flush_cnt !== 4'd0) begin errors++; $display("FAIL ht_frozen: got halted %b cycle %0d flush %0d expected 1 4 0", halted, cycle_cnt, flush_cnt); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        load_pc = 1'b1;
        tick();
        load_pc = 1'b0; halt_ex = 1'b1;
        tick();
        halt_ex = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr, halted} !== 5'b11000) begin errors++; $display("FAIL rd_outputs: got %b expected 11000", {pc_en, if_id_en, if_id_clr, id_ex_clr, halted}); end
        checks++; if (flush_cnt !== 4'd0 || cycle_cnt !== 4'd0) begin errors++; $display("FAIL rd_counters: got flush %0d cycle %0d expected 0 0", flush_cnt, cycle_cnt); end
        tick();
        rst_n = 1'b1;
        set_load_use();
        #1;
        checks++; if ({pc_en, id_ex_clr} !== 2'b01) begin errors++; $display("FAIL rd_run_after: got %b expected 01", {pc_en, id_ex_clr}); end
    endtask

    task automatic test_en_stall();
        apply_reset();
        set_load_use();
        tick();
        ex_is_load = 1'b0; ex_w_en = 1'b0; ex_req_w = 5'd0;
        dm_w_en = 1'b1; dm_req_w = 5'd8;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({pc_en, if_id_en, if_id_clr, id_ex_clr} !== 4'b0000) begin errors++; $display("FAIL en_ctrl_%0d: got %b expected 0000", i, {pc_en, if_id_en, if_id_clr, id_ex_clr}); end
            tick();
        end
        checks++; if (stall_cnt !== 4'd1 || cycle_cnt !== 4'd1 || flush_cnt !== 4'd0) begin errors++; $display("FAIL en_counters: got %0d %0d %0d expected 1 1 0", stall_cnt, cycle_cnt, flush_cnt); end
        en = 1'b1;
        #1;
        checks++; if ({pc_en, if_id_en, id_ex_clr} !== 3'b110 || fwd_a !== 2'b10) begin errors++; $display("FAIL en_resolve: got %b fwd %b expected 110 10", {pc_en, if_id_en, id_ex_clr}, fwd_a); end
        tick();
        checks++; if (cycle_cnt !== 4'd2 || stall_cnt !== 4'd1) begin errors++; $display("FAIL en_after: got cycle %0d stall %0d expected 2 1", cycle_cnt, stall_cnt); end
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (17) tick();
        checks++; if (cycle_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cycle: got %0d expected 1", cycle_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #3;
        test_reset();
        test_load_use();
        test_forward();
        test_flush();
        test_halt();
        test_reset_mid_drain();
        test_en_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
